// File: rtl/trace_pkg.sv
// Shared constants and types for the trace step packer and its downstream step checker.
package trace_pkg;
  localparam int STEP_W = 560;
  localparam int BEAT_W = 16;
  localparam int BEATS  = 35;
  localparam int CNT_W  = 6;
  localparam logic [BEAT_W-1:0] TRACE_HEADER = 16'h5A86;

  // Step field layout: instruction word, ten 32-bit registers, two 72-bit hints.
  localparam int INSTR_LSB = 0;
  localparam int INSTR_W   = 96;
  localparam int REGS_LSB  = 96;
  localparam int REG_W     = 32;
  localparam int NUM_REGS  = 10;
  localparam int HINT0_LSB = 416;
  localparam int HINT1_LSB = 488;
  localparam int HINT_W    = 72;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    COLLECT = 2'd1,
    STALL   = 2'd2
  } state_t;
endpackage

// File: rtl/trace_step_packer_if.sv
// Beat input channel and step output channel of the trace step packer.
interface trace_step_packer_if;
  import trace_pkg::*;

  // Both channels: a transfer happens on a rising edge where valid && ready;
  // valid never waits on ready, and a presented payload holds until transferred.
  logic              in_valid;
  logic [BEAT_W-1:0] in_data;
  logic              in_ready;
  logic              step_valid;
  logic [STEP_W-1:0] step;
  logic              step_ready;
  logic              frame_err;
  logic [31:0]       step_count;

  modport master (
    output in_valid, in_data, step_ready,
    input  in_ready, step_valid, step, frame_err, step_count
  );

  modport slave (
    input  in_valid, in_data, step_ready,
    output in_ready, step_valid, step, frame_err, step_count
  );
endinterface

// File: rtl/step_out_reg.sv
// One-entry holding register for completed steps, plus the handed-over step counter.
module step_out_reg
  import trace_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [STEP_W-1:0] load_data,
  input  logic              ready,
  output logic              valid,
  output logic [STEP_W-1:0] data,
  output logic [31:0]       count
);
  logic xfer;
  assign xfer = valid && ready;

  // The caller only loads when the register is empty or draining this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      count <= '0;
    end else begin
      if (load) begin
        valid <= 1'b1;
        data  <= load_data;
      end else if (xfer) begin
        valid <= 1'b0;
      end
      if (xfer) count <= count + 32'd1;
    end
  end
endmodule

// File: rtl/trace_step_packer.sv
// Hunts for a header, packs 35 beats LSB-first into a step, hands it to the output register.
module trace_step_packer
  import trace_pkg::*;
#(
  parameter logic [BEAT_W-1:0] HEADER = TRACE_HEADER
) (
  input  logic                clk,
  input  logic                rst_n,
  trace_step_packer_if.slave  bus,
  output state_t              state
);
  logic [CNT_W-1:0]  cnt;
  logic [STEP_W-1:0] asm_q;
  logic [STEP_W-1:0] asm_next;
  logic [STEP_W-1:0] load_data;
  logic              in_ready_q;
  logic              frame_err_q;
  logic              step_valid;
  logic              accept;
  logic              drain;
  logic              last;
  logic              load;

  assign accept = bus.in_valid && in_ready_q;
  assign drain  = step_valid && bus.step_ready;
  assign last   = (state == COLLECT) && accept && (cnt == CNT_W'(BEATS - 1));

  always_comb begin
    asm_next = asm_q;
    if (state == COLLECT && accept)
      asm_next[int'(cnt)*BEAT_W +: BEAT_W] = bus.in_data;
  end

  // In STALL the last beat is already in asm_q; otherwise include the beat arriving now.
  assign load      = (last && (!step_valid || drain)) || (state == STALL && drain);
  assign load_data = (state == STALL) ? asm_q : asm_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      cnt         <= '0;
      asm_q       <= '0;
      in_ready_q  <= 1'b1;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      asm_q       <= asm_next;
      case (state)
        HUNT: begin
          if (accept) begin
            if (bus.in_data == HEADER) begin
              state <= COLLECT;
              cnt   <= '0;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (accept) begin
            if (cnt == CNT_W'(BEATS - 1)) begin
              cnt <= '0;
              if (!step_valid || drain) begin
                state <= HUNT;
              end else begin
                state      <= STALL;
                in_ready_q <= 1'b0;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        STALL: begin
          if (drain) begin
            state      <= HUNT;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state      <= HUNT;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  step_out_reg u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (load_data),
    .ready     (bus.step_ready),
    .valid     (step_valid),
    .data      (bus.step),
    .count     (bus.step_count)
  );

  assign bus.step_valid = step_valid;
  assign bus.in_ready   = in_ready_q;
  assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_trace_step_packer.sv
// Scoreboard bench for trace_step_packer: expected steps queued at send, compared on handover.
module tb_trace_step_packer;
  import trace_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t state;

  trace_step_packer_if bus ();

  trace_step_packer #(.HEADER(TRACE_HEADER)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .state (state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [STEP_W-1:0] exp_q[$];
  int ready_mode = 0;   // 0: always ready, 1: never ready, 2: random
  int taken = 0;
  int ferr_cnt = 0;
  bit gaps = 1'b0;

  task automatic check(input string tag, input logic [STEP_W-1:0] got,
                       input logic [STEP_W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- consumer + scoreboard ----------------
  initial begin
    bus.step_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       bus.step_ready = 1'b1;
        1:       bus.step_ready = 1'b0;
        default: bus.step_ready = 1'($urandom_range(0, 1));
      endcase
      if (rst_n && bus.step_valid && bus.step_ready) begin
        if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
        else check("sb_step", bus.step, exp_q.pop_front());
        taken++;
      end
      if (bus.frame_err) ferr_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [BEAT_W-1:0] d);
    int n = 0;
    bit ok = 1'b0;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!ok && n < 1000) begin
      ok = bus.in_ready;
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b0;
    if (!ok) check("send_timeout", ok, 1);
  endtask

  task automatic send_step(input logic [STEP_W-1:0] s, input bit push);
    if (push) exp_q.push_back(s);
    send_word(TRACE_HEADER);
    for (int k = 0; k < BEATS; k++) send_word(s[k*BEAT_W +: BEAT_W]);
  endtask

  function automatic logic [STEP_W-1:0] rand_step();
    logic [STEP_W-1:0] s;
    for (int k = 0; k < BEATS; k++) s[k*BEAT_W +: BEAT_W] = BEAT_W'($urandom);
    return s;
  endfunction

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [STEP_W-1:0] s;
    logic [STEP_W-1:0] a;
    logic [STEP_W-1:0] b;
    int f0;

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_step_valid", bus.step_valid, 0);
    check("rst_step", bus.step, 0);
    check("rst_count", bus.step_count, 0);
    check("rst_frame_err", bus.frame_err, 0);
    check("rst_state", state, HUNT);
    rst_n = 1'b1;
    @(negedge clk);

    // Incrementing beats, consumer always ready.
    for (int k = 0; k < BEATS; k++) s[k*BEAT_W +: BEAT_W] = BEAT_W'(k);
    send_step(s, 1'b1);
    check("lat_valid", bus.step_valid, 1);
    check("seq_lo", bus.step[15:0], 16'h0000);
    check("seq_hi", bus.step[559:544], 16'h0022);
    wait_drain();
    check("seq_count", bus.step_count, 1);

    // Garbage before a header.
    f0 = ferr_cnt;
    send_word(16'h1234);
    check("ferr_pulse1", bus.frame_err, 1);
    send_word(16'hFFFF);
    check("ferr_pulse2", bus.frame_err, 1);
    @(negedge clk);
    check("ferr_clear", bus.frame_err, 0);
    send_step(rand_step(), 1'b1);
    wait_drain();
    check("ferr_total", ferr_cnt - f0, 2);
    check("ferr_count", bus.step_count, 2);

    // Two steps against a stalled consumer.
    ready_mode = 1;
    @(negedge clk);
    a = rand_step();
    b = rand_step();
    send_step(a, 1'b1);
    send_step(b, 1'b1);
    check("stall_in_ready", bus.in_ready, 0);
    check("stall_state", state, STALL);
    check("stall_hold_a", bus.step, a);
    repeat (4) @(negedge clk);
    check("stall_still_a", bus.step, a);
    ready_mode = 0;
    repeat (3) @(negedge clk);
    check("stall_exit_ready", bus.in_ready, 1);
    wait_drain();
    check("stall_count", bus.step_count, 4);

    // Header value inside the payload is plain data.
    s = rand_step();
    s[10*BEAT_W +: BEAT_W] = TRACE_HEADER;
    f0 = ferr_cnt;
    send_step(s, 1'b1);
    check("hdr_in_payload", bus.step[175:160], 16'h5A86);
    wait_drain();
    check("hdr_no_ferr", ferr_cnt - f0, 0);
    check("hdr_state", state, HUNT);

    // Reset in the middle of a step.
    send_word(TRACE_HEADER);
    for (int k = 0; k < 20; k++) send_word(BEAT_W'($urandom));
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.step_valid, 0);
    check("mid_rst_step", bus.step, 0);
    check("mid_rst_count", bus.step_count, 0);
    check("mid_rst_ready", bus.in_ready, 1);
    check("mid_rst_state", state, HUNT);
    @(negedge clk);
    rst_n = 1'b1;
    taken = 0;
    @(negedge clk);
    send_step(rand_step(), 1'b1);
    wait_drain();
    check("post_rst_count", bus.step_count, 1);

    // 100 random steps with random gaps on both sides.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    gaps = 1'b1;
    ready_mode = 2;
    for (int i = 0; i < 100; i++) send_step(rand_step(), 1'b1);
    ready_mode = 0;
    wait_drain();
    check("rand_count", bus.step_count, 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/trace_step_packer.md
# trace_step_packer

Streaming front end that builds 560-bit trace steps for the step checker from a narrow 16-bit trace channel. It hunts for a per-step header, collects 35 payload beats LSB-first into an assembly register, and hands completed steps to a one-entry output register with a valid/ready handshake. Assembly of step N+1 overlaps with the consumer holding step N. It sits between the trace source (host DMA / FIFO) and the checker's `step` input.

## Interface
Parameters:
- `HEADER`, 16'h5A86, framing word that must precede every step
- `BEATS`, 35, payload beats per step (560 / 16); fixed, not for override

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  source has a beat
- `in_data`  in  16  beat payload
- `in_ready`  out  1  packer accepts the beat this cycle
- `step_valid`  out  1  `step` holds a complete step
- `step`  out  560  assembled step; beat k occupies bits [16k+15:16k]
- `step_ready`  in  1  consumer takes the step this cycle
- `frame_err`  out  1  one-cycle pulse: non-header word seen while hunting
- `step_count`  out  32  number of steps handed over (counts `step_valid && step_ready`)

## Operation
- Beat transfer when `in_valid && in_ready`; step transfer when `step_valid && step_ready`.
- FSM states: HUNT, COLLECT, STALL.
- HUNT: `in_ready`=1. An accepted word == `HEADER` -> COLLECT, beat counter = 0. Any other accepted word is discarded, `frame_err` pulses next cycle, stay HUNT.
- COLLECT: `in_ready`=1. Each accepted beat is written to assembly slot `cnt`, `cnt`++. At `cnt`==34 accepted:
  - output register empty, or being drained this same cycle -> copy the assembled step (including this beat) into the output register, `step_valid`=1 next cycle, -> HUNT.
  - otherwise -> STALL.
- STALL: `in_ready`=0. When output register drains (step transfer), the assembly register is copied into the output register the same edge, `step_valid` stays 1, -> HUNT.
- Headers are not checked inside COLLECT: a word equal to `HEADER` in the payload is data.
- `step` is stable while `step_valid`=1 and not transferred; `step_valid` only drops on transfer with no replacement.
- `step_count` wraps modulo 2^32.

## Timing
- Reset (async assert, sync-released use): state HUNT, `cnt`=0, `step_valid`=0, `step`=0, `frame_err`=0, `step_count`=0, `in_ready`=1. Reset mid-step discards partial and held steps.
- `in_ready` is a function of state only (no combinational path from `step_ready` or `in_valid`).
- Latency: last payload beat accepted at cycle N -> `step_valid`=1 at N+1.
- Peak throughput: one step per 36 beats (header + 35), no bubbles when consumer is always ready.
- Simultaneous last beat and drain of previous step: both occur; new step visible at N+1, no STALL.
- `frame_err` asserted exactly one cycle per rejected word, cycle after acceptance.
- `step_count` increments the cycle after each step transfer.

## Structure
- Shared package (`trace_pkg`): `STEP_W`=560, `BEAT_W`=16, `BEATS`=35, `TRACE_HEADER`=16'h5A86, FSM state enum; field offsets of the step (instr 96, 10×32 registers, two 72-bit hints) belong there too for the checker and bench.
- One sub-module natural: `step_out_reg`, the one-entry valid/ready holding register with load/drain logic. The FSM, counter, and assembly register live in the top.

## Test plan
- Header 5A86 then beats 0x0000..0x0022, `step_ready`=1 -> `step_valid` one cycle after beat 34; `step[15:0]`=0x0000, `step[559:544]`=0x0022; `step_count`=1.
- Words 0x1234, 0xFFFF then header + 35 beats -> two `frame_err` pulses, then one correct step; `step_count`=1.
- Two back-to-back steps, `step_ready`=0 until both assembled -> `in_ready` drops after second step's beat 34 (STALL); on `step_ready`=1 first step exits, second presented next cycle unchanged, `in_ready` returns to 1.
- Payload containing 0x5A86 at beat 10 -> treated as data, `step[175:160]`=0x5A86, no reframe.
- `rst_n` pulsed low after header + 20 beats -> all outputs at reset values immediately; following header + 35 beats yields a clean step with no residue from the aborted one.
- Continuous 100 steps with random `in_valid`/`step_ready` gaps, scoreboard vs. reference packer -> all steps match in order, `step_count`=100.
